// File: rtl/mul_err_sweep_ctrl.sv
// Error-characterisation sweep controller for a combinational approximate multiplier.
// Drives operands, waits SETTLE cycles, samples the product and accumulates error statistics.
module mul_err_sweep_ctrl #(
    parameter int W = 8,
    parameter int SETTLE = 2,
    parameter int ACC_W = 32,
    parameter logic [2*W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [2*W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_i,
    input  logic [ACC_W-1:0] n_samples_i,
    output logic [W-1:0]     op_a_o,
    output logic [W-1:0]     op_b_o,
    input  logic [2*W-1:0]   apprx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] sample_count_o,
    output logic [ACC_W-1:0] err_count_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic [ACC_W-1:0] sum_abs_ed_o,
    output logic [2*W-1:0]   max_ed_o
);
    localparam int PW = 2 * W;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam state_e S_WAIT = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_e state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [PW-1:0]    lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [ACC_W-1:0] nsamp_q, nsamp_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [ACC_W-1:0] scnt_q, scnt_d, err_q, err_d;
    logic [ACC_W-1:0] sed_q, sed_d, sabs_q, sabs_d;
    logic [PW-1:0]    max_q, max_d;

    logic [PW-1:0]    exact, abs_ed, lfsr_nxt;
    logic [PW:0]      ed;
    logic [ACC_W-1:0] ed_sx, cnt_inc;
    logic [ACC_W:0]   abs_sum;
    logic             last;

    assign exact    = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};
    assign ed       = {1'b0, exact} - {1'b0, apprx_i};
    assign abs_ed   = ed[PW] ? PW'(-ed) : ed[PW-1:0];
    assign ed_sx    = ACC_W'($signed(ed));
    assign abs_sum  = {1'b0, sabs_q} + (ACC_W + 1)'(abs_ed);
    assign cnt_inc  = scnt_q + ACC_W'(1);
    assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign last     = mode_q ? (cnt_inc == nsamp_q) : (&op_a_q & &op_b_q);

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        nsamp_d = nsamp_q;
        done_d  = done_q;
        scnt_d  = scnt_q;
        err_d   = err_q;
        sed_d   = sed_q;
        sabs_d  = sabs_q;
        max_d   = max_q;
        // Abort beats both start and the completion of a pending sample.
        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        done_d  = 1'b0;
                        scnt_d  = '0;
                        err_d   = '0;
                        sed_d   = '0;
                        sabs_d  = '0;
                        max_d   = '0;
                        mode_d  = mode_i;
                        nsamp_d = n_samples_i;
                        cnt_d   = SETTLE_LD;
                        state_d = S_WAIT;
                        if (mode_i) begin
                            lfsr_d           = LFSR_SEED;
                            {op_a_d, op_b_d} = LFSR_SEED;
                            if (n_samples_i == '0) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            op_a_d = '0;
                            op_b_d = '0;
                        end
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    scnt_d = cnt_inc;
                    err_d  = err_q + ACC_W'(ed != '0);
                    sed_d  = sed_q + ed_sx;
                    sabs_d = abs_sum[ACC_W] ? '1 : abs_sum[ACC_W-1:0];
                    if (abs_ed > max_q) begin
                        max_d = abs_ed;
                    end
                    if (last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = SETTLE_LD;
                        state_d = S_WAIT;
                        if (mode_q) begin
                            lfsr_d           = lfsr_nxt;
                            {op_a_d, op_b_d} = lfsr_nxt;
                        end else begin
                            op_a_d = op_a_q + W'(1);
                            if (&op_a_q) begin
                                op_b_d = op_b_q + W'(1);
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            nsamp_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scnt_q  <= '0;
            err_q   <= '0;
            sed_q   <= '0;
            sabs_q  <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            nsamp_q <= nsamp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scnt_q  <= scnt_d;
            err_q   <= err_d;
            sed_q   <= sed_d;
            sabs_q  <= sabs_d;
            max_q   <= max_d;
        end
    end

    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sample_count_o = scnt_q;
    assign err_count_o    = err_q;
    assign sum_ed_o       = sed_q;
    assign sum_abs_ed_o   = sabs_q;
    assign max_ed_o       = max_q;
endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Bench for mul_err_sweep_ctrl: a 4-bit instance driven by a multiplier stub,
// results compared against a sample-list reference model.
module tb_mul_err_sweep_ctrl;
    localparam int W = 4;
    localparam int PW = 8;
    localparam int S = 2;
    localparam int AW = 12;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'hE1;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst, start, abort, mode;
    logic [AW-1:0] nsamp;
    logic [W-1:0] op_a, op_b;
    logic [PW-1:0] apprx;
    logic busy, done;
    logic [AW-1:0] scnt, ecnt, sed, sabs;
    logic [PW-1:0] mx;

    int checks = 0;
    int errors = 0;
    int stub_kind = 0;
    logic [PW-1:0] mask = '0;

    longint exp_cnt, exp_err, exp_sed, exp_sabs, exp_max;
    logic [7:0] exp_ops[$];
    logic [7:0] got_ops[$];
    int cyc;

    mul_err_sweep_ctrl #(
        .W(W), .SETTLE(S), .ACC_W(AW),
        .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .mode_i(mode), .n_samples_i(nsamp),
        .op_a_o(op_a), .op_b_o(op_b), .apprx_i(apprx),
        .busy_o(busy), .done_o(done),
        .sample_count_o(scnt), .err_count_o(ecnt),
        .sum_ed_o(sed), .sum_abs_ed_o(sabs), .max_ed_o(mx)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] stub_f(input int kind, input logic [PW-1:0] m,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        case (kind)
            0: return PW'(p);
            1: return PW'(p & ~1);
            2: return '0;
            default: return PW'(p) ^ m;
        endcase
    endfunction

    always_comb apprx = stub_f(stub_kind, mask, op_a, op_b);

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: list the operand pairs in sweep order, then fold the error rules over it.
    task automatic model(input bit md, input int n);
        longint s, sa, d, ad;
        int c, e, mxv, a, b;
        logic [7:0] l;
        s = 0; sa = 0; c = 0; e = 0; mxv = 0;
        l = SEED;
        exp_ops.delete();
        if (!md) begin
            for (int bi = 0; bi < 16; bi++)
                for (int ai = 0; ai < 16; ai++)
                    exp_ops.push_back(8'(ai * 16 + bi));
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_ops.push_back(l);
                l = (l >> 1) ^ (l[0] ? TAPS : 8'h00);
            end
        end
        foreach (exp_ops[i]) begin
            a = int'(exp_ops[i][7:4]);
            b = int'(exp_ops[i][3:0]);
            d = longint'(a * b) - longint'(stub_f(stub_kind, mask, 4'(a), 4'(b)));
            ad = (d < 0) ? -d : d;
            c++;
            if (d != 0) e++;
            s += d;
            sa += ad;
            if (ad > mxv) mxv = int'(ad);
        end
        exp_cnt = c;
        exp_err = e;
        exp_sed = s & 64'hFFF;
        exp_sabs = (sa > 4095) ? 4095 : sa;
        exp_max = mxv;
    endtask

    task automatic run(input bit md, input int n, input int glitch);
        got_ops.delete();
        mode = md;
        nsamp = AW'(n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("clear", {scnt, ecnt, sed, sabs, mx}, 0);
        got_ops.push_back({op_a, op_b});
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            if (cyc == glitch) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
            if ({op_a, op_b} !== got_ops[$]) got_ops.push_back({op_a, op_b});
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        int mis;
        chk({tag, ".cycles"}, cyc, exp_ops.size() * (S + 1));
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".count"}, scnt, exp_cnt);
        chk({tag, ".err"}, ecnt, exp_err);
        chk({tag, ".sum_ed"}, sed, exp_sed);
        chk({tag, ".sum_abs"}, sabs, exp_sabs);
        chk({tag, ".max_ed"}, mx, exp_max);
        if (exp_ops.size() > 0) begin
            mis = (got_ops.size() != exp_ops.size()) ? 1 : 0;
            foreach (exp_ops[i])
                if (i < got_ops.size() && got_ops[i] !== exp_ops[i]) mis++;
            chk({tag, ".opseq"}, mis, 0);
        end
    endtask

    initial begin
        int m;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; nsamp = '0;
        #1;
        chk("rst.flags", {op_a, op_b, busy, done}, 0);
        chk("rst.counts", {scnt, ecnt, sed, sabs, mx}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        stub_kind = 0; model(0, 0); run(0, 0, -1); check_run("exh.exact");
        stub_kind = 1; model(0, 0); run(0, 0, -1); check_run("exh.bit0");
        chk("exh.bit0.err_const", ecnt, 64);
        stub_kind = 2; model(0, 0); run(0, 0, -1); check_run("exh.zero");
        chk("exh.zero.max_const", mx, 225);
        chk("exh.zero.sat_const", sabs, 4095);

        stub_kind = 0; model(1, 5); run(1, 5, -1); check_run("rnd5");
        chk("rnd5.first_ops", got_ops[0], SEED);
        model(1, 0); run(1, 0, -1); check_run("rnd0");

        for (int r = 0; r < 4; r++) begin
            stub_kind = 3;
            mask = PW'($urandom_range(1, 255));
            m = (r == 0) ? 0 : $urandom_range(1, 300);
            model(r != 0, m);
            run(r != 0, m, $urandom_range(0, 40));
            check_run($sformatf("rand%0d", r));
        end

        stub_kind = 3;
        mask = PW'($urandom_range(1, 255));
        m = $urandom_range(2, 40);
        mode = 1'b1;
        nsamp = AW'(200);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3 * m - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model(1, m - 1);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.count", scnt, exp_cnt);
        chk("abort.err", ecnt, exp_err);
        chk("abort.sum_ed", sed, exp_sed);
        chk("abort.max_ed", mx, exp_max);
        stub_kind = 0; model(1, 7); run(1, 7, -1); check_run("after_abort");

        stub_kind = 3;
        mode = 1'b1;
        nsamp = AW'(100);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.flags", {op_a, op_b, busy, done}, 0);
        chk("midrst.counts", {scnt, ecnt, sed, sabs, mx}, 0);
        @(negedge clk);
        rst = 1'b0;
        model(1, 30); run(1, 30, 5); check_run("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
